tpu_spi_slave: RTL and testbench

//  SPI mode-0 slave that bridges the external host to the TPU MMIO register file.

---
 rtl/tpu_spi_pkg.sv | 9 +
 rtl/tpu_spi_if.sv | 17 +
 rtl/tpu_sync_edge.sv | 24 ++
 rtl/tpu_spi_slave.sv | 111 +++++++++++
 tb/tb_tpu_spi_slave.sv | 138 +++++++++++++
 5 files changed

// File: rtl/tpu_spi_pkg.sv
// tpu_spi_pkg: shared types and frame constants for the SPI-to-MMIO bridge.
package tpu_spi_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_LSB = 0;
    localparam int FRAME_BITS   = 16;
    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 8;
endpackage

// File: rtl/tpu_spi_if.sv
// tpu_spi_if: SPI pins plus MMIO register-file strobe bus.
interface tpu_spi_if;
    import tpu_spi_pkg::*;
    logic              spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_rd, reg_wr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;
    logic              reg_addr_valid, reg_writable, xfer_done, xfer_err;
    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, reg_rdata, reg_addr_valid, reg_writable,
        output spi_miso, reg_addr, reg_rd, reg_wr, reg_wdata, xfer_done, xfer_err
    );
    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, reg_rdata, reg_addr_valid, reg_writable,
        input  spi_miso, reg_addr, reg_rd, reg_wr, reg_wdata, xfer_done, xfer_err
    );
endinterface

// File: rtl/tpu_sync_edge.sv
// tpu_sync_edge: N-flop synchronizer with rise/fall pulses on the synchronized level.
module tpu_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [N-1:0] sync_q;
    logic         prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
            prev_q <= sync_q[N-1];
        end
    end
    assign rise_o = sync_q[N-1] & ~prev_q;
    assign fall_o = ~sync_q[N-1] & prev_q;
endmodule

// File: rtl/tpu_spi_slave.sv
// tpu_spi_slave: SPI mode-0 slave decoding 2-byte frames into MMIO read/write strobes.
module tpu_spi_slave
    import tpu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    tpu_spi_if.slave bus
);
    logic                   sclk_rise, sclk_fall, cs_n_s, mosi_s, rd_ok, wr_ok;
    logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_q, rx_d, tx_q, tx_d, rx_shift;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rw_q, rw_d, ld_q, ld_d, fin_q, fin_d;

    tpu_sync_edge #(.N(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign rx_shift = {rx_q[DATA_W-2:0], mosi_s};
    // Strobes fire one clk after the decoding rise so reg_addr is already stable.
    assign rd_ok    = ld_q && !rw_q && bus.reg_addr_valid;
    assign wr_ok    = fin_q && rw_q && bus.reg_addr_valid && bus.reg_writable;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        ld_d      = 1'b0;
        fin_d     = 1'b0;
        case (state_q)
            IDLE: if (!cs_n_s) begin
                state_d   = CMD;
                bit_cnt_d = '0;
                rx_d      = '0;
                tx_d      = '0;
            end
            CMD: if (cs_n_s) state_d = IDLE;
            else if (sclk_rise) begin
                rx_d      = rx_shift;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(FRAME_BITS / 2 - 1)) begin
                    state_d = DATA;
                    ld_d    = 1'b1;
                    rw_d    = rx_shift[CMD_RW_BIT];
                    addr_d  = rx_shift[CMD_ADDR_LSB +: ADDR_W];
                end
            end
            DATA: if (cs_n_s) state_d = IDLE;
            else begin
                // The fall right after the command byte must keep the freshly loaded MSB.
                if (ld_q) tx_d = rd_ok ? bus.reg_rdata : '0;
                else if (sclk_fall && bit_cnt_q != 4'(FRAME_BITS / 2)) tx_d = {tx_q[DATA_W-2:0], 1'b0};
                if (sclk_rise) begin
                    rx_d      = rx_shift;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                    end
                end
            end
            DONE: if (cs_n_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) addr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            ld_q        <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            ld_q        <= ld_d;
            fin_q       <= fin_d;
        end
    end

    assign bus.spi_miso  = (state_q == DATA) && tx_q[DATA_W-1];
    assign bus.reg_addr  = addr_q;
    assign bus.reg_rd    = rd_ok;
    assign bus.reg_wr    = wr_ok;
    assign bus.reg_wdata = wr_ok ? rx_q : '0;
    assign bus.xfer_done = fin_q;
    assign bus.xfer_err  = (ld_q && !rw_q && !bus.reg_addr_valid) ||
                           (fin_q && rw_q && !(bus.reg_addr_valid && bus.reg_writable));
endmodule

// File: tb/tb_tpu_spi_slave.sv
// tb_tpu_spi_slave: directed SPI frames against a tiny register-file model.
module tb_tpu_spi_slave;
    import tpu_spi_pkg::*;
    localparam int H = 6;
    logic clk = 1'b0, rst_n = 1'b0;
    int   total = 0, bad = 0;
    int   rd_cnt, wr_cnt, err_cnt, done_cnt, clash_cnt;
    logic [3:0] rd_addr, wr_addr;
    logic [7:0] wr_data, mb;

    tpu_spi_if bus();
    tpu_spi_slave #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Registers 0..3 exist; register 1 is a read-only status register.
    always_comb begin
        bus.reg_addr_valid = bus.reg_addr <= 4'd3;
        bus.reg_writable   = bus.reg_addr_valid && bus.reg_addr != 4'd1;
        bus.reg_rdata      = bus.reg_addr == 4'd1 ? 8'h05 : {4'hA, bus.reg_addr};
    end

    always @(negedge clk) begin
        if (bus.reg_rd) begin rd_cnt++; rd_addr = bus.reg_addr; end
        if (bus.reg_wr) begin wr_cnt++; wr_addr = bus.reg_addr; wr_data = bus.reg_wdata; end
        if (bus.xfer_err) err_cnt++;
        if (bus.xfer_done) done_cnt++;
        if (int'(bus.reg_rd) + int'(bus.reg_wr) + int'(bus.xfer_err) > 1) clash_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rd_cnt = 0; wr_cnt = 0; err_cnt = 0; done_cnt = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic send_bits(input logic [15:0] f, input int nbits, output logic [7:0] m);
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = f[15-i];
            repeat (H) @(negedge clk);
            if (i >= 8) m = {m[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            repeat (H) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits, output logic [7:0] m);
        clr();
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits({cmd, data}, nbits, m);
        bus.spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out"}, {bus.spi_miso, bus.reg_addr, bus.reg_rd, bus.reg_wr, bus.reg_wdata,
                            bus.xfer_done, bus.xfer_err}, '0);
    endtask

    initial begin
        clash_cnt = 0;
        clr();
        bus.spi_sclk = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        frame(8'h82, 8'h05, 16, mb);
        chk("wr_cnt", wr_cnt, 1);
        chk("wr_addr", wr_addr, 2);
        chk("wr_data", wr_data, 8'h05);
        chk("wr_done", done_cnt, 1);
        chk("wr_err", err_cnt, 0);

        frame(8'h01, 8'h00, 16, mb);
        chk("rd_cnt", rd_cnt, 1);
        chk("rd_addr", rd_addr, 1);
        chk("rd_miso", mb, 8'h05);
        chk("rd_done", done_cnt, 1);
        chk("rd_err", err_cnt, 0);

        frame(8'h02, 8'h00, 16, mb);
        chk("rd2_miso", mb, 8'hA2);

        frame(8'h81, 8'hFF, 16, mb);
        chk("ro_wr_cnt", wr_cnt, 0);
        chk("ro_err", err_cnt, 1);
        chk("ro_done", done_cnt, 1);

        frame(8'h0F, 8'h00, 16, mb);
        chk("bad_rd_cnt", rd_cnt, 0);
        chk("bad_miso", mb, 8'h00);
        chk("bad_err", err_cnt, 1);
        chk("bad_done", done_cnt, 1);

        frame(8'h83, 8'h3C, 12, mb);
        chk("abort_wr", wr_cnt, 0);
        chk("abort_done", done_cnt, 0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        frame(8'h83, 8'h3C, 16, mb);
        chk("post_abort_wr", wr_cnt, 1);
        chk("post_abort_data", {wr_addr, wr_data}, 12'h33C);

        clr();
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(16'h82AA, 10, mb);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        bus.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_wr", wr_cnt, 0);
        chk("midrst_done", done_cnt, 0);
        frame(8'h82, 8'h5A, 16, mb);
        chk("post_rst_wr", wr_cnt, 1);
        chk("post_rst_data", {wr_addr, wr_data}, 12'h25A);

        chk("strobe_clash", clash_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
